// File: rtl/ycr1_imem_router_np.sv
// Instruction-fetch router: decodes the core imem request onto one of NPORT
// memory ports, keeps up to DEPTH fetches in flight and returns them in order.
module ycr1_imem_router_np #(
  parameter int                  NPORT        = 3,
  parameter int                  AW           = 32,
  parameter int                  DW           = 32,
  parameter int                  DEPTH        = 2,
  parameter logic [NPORT*AW-1:0] PORT_MASK    = {NPORT{32'hFFFF0000}},
  parameter logic [NPORT*AW-1:0] PORT_PATTERN = {32'h00020000, 32'h00010000, 32'h0},
  parameter bit                  UNMAP_ERR    = 1'b0
) (
  input  logic                rst_n,
  input  logic                clk,
  input  logic                imem_req,
  output logic                imem_req_ack,
  input  logic                imem_cmd,
  input  logic [AW-1:0]       imem_addr,
  output logic [DW-1:0]       imem_rdata,
  output logic [1:0]          imem_resp,
  output logic [NPORT-1:0]    port_req,
  input  logic [NPORT-1:0]    port_req_ack,
  output logic                port_cmd,
  output logic [AW-1:0]       port_addr,
  input  logic [NPORT*DW-1:0] port_rdata,
  input  logic [NPORT*2-1:0]  port_resp
);

  localparam int            CW        = $clog2(DEPTH + 1);
  localparam int            PW        = $clog2(NPORT + 1);
  localparam logic [PW-1:0] ERR_IDX   = PW'(NPORT);
  localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [1:0]    RESP_IDLE = 2'b00;
  localparam logic [1:0]    RESP_ER   = 2'b10;

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    cur_port_q, cur_port_d;
  logic [NPORT-1:1] match;
  logic [PW-1:0]    sel;
  logic             sel_ack;
  logic             retire;
  logic             can_issue;
  logic             issue;

  genvar gi;

  generate
    for (gi = 1; gi < NPORT; gi++) begin : g_match
      assign match[gi] = (imem_addr & PORT_MASK[gi*AW +: AW]) == PORT_PATTERN[gi*AW +: AW];
    end
  endgenerate

  // Descending scan so the lowest matching port wins.
  always_comb begin
    sel = UNMAP_ERR ? ERR_IDX : '0;
    for (int i = NPORT - 1; i >= 1; i--) begin
      if (match[i]) sel = PW'(i);
    end
  end

  always_comb begin
    sel_ack = (sel == ERR_IDX);
    for (int i = 0; i < NPORT; i++) begin
      if (sel == PW'(i)) sel_ack = port_req_ack[i];
    end
  end

  always_comb begin
    imem_resp  = RESP_IDLE;
    imem_rdata = '0;
    if (cnt_q != '0) begin
      if (cur_port_q == ERR_IDX) begin
        imem_resp = RESP_ER;
      end else begin
        for (int i = 0; i < NPORT; i++) begin
          if (cur_port_q == PW'(i)) begin
            imem_resp  = port_resp[2*i +: 2];
            imem_rdata = port_rdata[i*DW +: DW];
          end
        end
      end
    end
  end

  assign retire = (cnt_q != '0) & (imem_resp != RESP_IDLE);

  // A different target is only reachable once every older fetch has drained.
  assign can_issue = ((cnt_q < CNT_FULL) | retire)
                   & ((cnt_q == '0) | (sel == cur_port_q) | ((cnt_q == CNT_ONE) & retire));

  generate
    for (gi = 0; gi < NPORT; gi++) begin : g_req
      assign port_req[gi] = imem_req & can_issue & (sel == PW'(gi));
    end
  endgenerate

  assign imem_req_ack = can_issue & imem_req & sel_ack;
  assign issue        = imem_req & imem_req_ack;
  assign port_cmd     = imem_cmd;
  assign port_addr    = imem_addr;

  always_comb begin
    cnt_d      = cnt_q;
    cur_port_d = cur_port_q;
    if (issue & ~retire) begin
      cnt_d = cnt_q + CNT_ONE;
    end else if (~issue & retire) begin
      cnt_d = cnt_q - CNT_ONE;
    end
    if (issue) cur_port_d = sel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      cur_port_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      cur_port_q <= cur_port_d;
    end
  end

`ifndef SYNTHESIS
  a_req_known: assert property (@(posedge clk) disable iff (!rst_n)
    imem_req |-> !$isunknown({imem_addr, imem_cmd}));
  a_cnt_bound: assert property (@(posedge clk) disable iff (!rst_n)
    cnt_q <= CNT_FULL);
  a_req_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(port_req));
`endif

endmodule

// File: tb/tb_ycr1_imem_router_np.sv
// Bench for ycr1_imem_router_np: two instances (unmapped->port0, unmapped->error)
// driven in lockstep and compared every cycle against a queue-based fetch model.
module tb_ycr1_imem_router_np;

  localparam int DEPTH = 2;
  localparam int ERRP  = 3;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic        imem_cmd;
  logic [31:0] imem_addr;
  logic [2:0]  port_req_ack;
  logic [95:0] port_rdata;
  logic [5:0]  port_resp;

  logic        ack0, ack1;
  logic [31:0] rdata0, rdata1;
  logic [1:0]  resp0, resp1;
  logic [2:0]  preq0, preq1;
  logic        pcmd0, pcmd1;
  logic [31:0] paddr0, paddr1;

  int q0[$];
  int q1[$];
  int passed;
  int total;

  ycr1_imem_router_np #(.DEPTH(DEPTH), .UNMAP_ERR(1'b0)) dut0 (
    .rst_n(rst_n), .clk(clk), .imem_req(imem_req), .imem_req_ack(ack0),
    .imem_cmd(imem_cmd), .imem_addr(imem_addr), .imem_rdata(rdata0), .imem_resp(resp0),
    .port_req(preq0), .port_req_ack(port_req_ack), .port_cmd(pcmd0), .port_addr(paddr0),
    .port_rdata(port_rdata), .port_resp(port_resp));

  ycr1_imem_router_np #(.DEPTH(DEPTH), .UNMAP_ERR(1'b1)) dut1 (
    .rst_n(rst_n), .clk(clk), .imem_req(imem_req), .imem_req_ack(ack1),
    .imem_cmd(imem_cmd), .imem_addr(imem_addr), .imem_rdata(rdata1), .imem_resp(resp1),
    .port_req(preq1), .port_req_ack(port_req_ack), .port_cmd(pcmd1), .port_addr(paddr1),
    .port_rdata(port_rdata), .port_resp(port_resp));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
  endtask

  // Address map of the default parameter set: 0x0001xxxx -> 1, 0x0002xxxx -> 2.
  function automatic int target(input logic [31:0] a, input bit unmap);
    case (a[31:16])
      16'h0001: return 1;
      16'h0002: return 2;
      default:  return unmap ? ERRP : 0;
    endcase
  endfunction

  task automatic check_one(input string tag, input bit unmap, input int size, input int head,
                           input logic ack, input logic [31:0] rdata, input logic [1:0] resp,
                           input logic [2:0] preq, input logic pcmd, input logic [31:0] paddr,
                           input int cnt, output bit issue, output bit retire, output int sel);
    logic [1:0]  e_resp;
    logic [31:0] e_rdata;
    logic [3:0]  ack_ext;
    logic [2:0]  e_preq;
    int          left;
    bit          allowed;
    e_resp  = 2'b00;
    e_rdata = '0;
    if (size > 0) begin
      if (head == ERRP) e_resp = 2'b10;
      else begin
        e_resp  = port_resp[2*head +: 2];
        e_rdata = port_rdata[32*head +: 32];
      end
    end
    retire  = (size > 0) && (e_resp != 2'b00);
    sel     = target(imem_addr, unmap);
    left    = size - (retire ? 1 : 0);
    allowed = (left < DEPTH) && (left == 0 || sel == head);
    ack_ext = {1'b1, port_req_ack};
    issue   = imem_req && allowed && ack_ext[sel];
    e_preq  = (imem_req && allowed && sel != ERRP) ? (3'b001 << sel) : 3'b000;
    chk({tag, "_resp"},  32'(resp), 32'(e_resp));
    chk({tag, "_rdata"}, rdata, e_rdata);
    chk({tag, "_ack"},   32'(ack), 32'(issue));
    chk({tag, "_preq"},  32'(preq), 32'(e_preq));
    chk({tag, "_pcmd"},  32'(pcmd), 32'(imem_cmd));
    chk({tag, "_paddr"}, paddr, imem_addr);
    chk({tag, "_cnt"},   32'(cnt), 32'(size));
  endtask

  task automatic step(input logic req, input logic [31:0] addr, input logic [2:0] ack,
                      input logic [5:0] resp, input logic [95:0] rdata);
    bit iss0, ret0, iss1, ret1;
    int sel0, sel1;
    @(negedge clk);
    imem_req     = req;
    imem_addr    = addr;
    imem_cmd     = 1'($urandom_range(0, 1));
    port_req_ack = ack;
    port_resp    = resp;
    port_rdata   = rdata;
    #1;
    check_one("u0", 1'b0, q0.size(), (q0.size() > 0) ? q0[0] : 0, ack0, rdata0, resp0,
              preq0, pcmd0, paddr0, int'(dut0.cnt_q), iss0, ret0, sel0);
    check_one("u1", 1'b1, q1.size(), (q1.size() > 0) ? q1[0] : 0, ack1, rdata1, resp1,
              preq1, pcmd1, paddr1, int'(dut1.cnt_q), iss1, ret1, sel1);
    $display("step req=%0b addr=%08h ack=%03b resp=%06b | u0 ack=%0b resp=%0d | u1 ack=%0b resp=%0d",
             req, addr, ack, resp, ack0, resp0, ack1, resp1);
    if (ret0) void'(q0.pop_front());
    if (iss0) q0.push_back(sel0);
    if (ret1) void'(q1.pop_front());
    if (iss1) q1.push_back(sel1);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst_n        = 1'b0;
    imem_req     = 1'b0;
    port_req_ack = '0;
    port_resp    = '0;
    #1;
    q0.delete();
    q1.delete();
    chk("rst_cnt0",  32'(dut0.cnt_q), 0);
    chk("rst_cnt1",  32'(dut1.cnt_q), 0);
    chk("rst_resp0", 32'(resp0), 0);
    chk("rst_resp1", 32'(resp1), 0);
    chk("rst_rdata0", rdata0, 0);
    chk("rst_preq0", 32'(preq0), 0);
    $display("reset asserted for %0d cycles", cycles);
    repeat (cycles) @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [1:0] rnd_resp();
    int r;
    r = $urandom_range(0, 99);
    if (r < 50) return 2'b00;
    if (r < 85) return 2'b01;
    return 2'b10;
  endfunction

  function automatic logic [31:0] rnd_addr();
    logic [15:0] lo;
    lo = 16'($urandom);
    case ($urandom_range(0, 3))
      0:       return {16'h0000, lo};
      1:       return {16'h0001, lo};
      2:       return {16'h0002, lo};
      default: return {16'h8000, lo};
    endcase
  endfunction

  initial begin
    clk          = 1'b0;
    rst_n        = 1'b0;
    imem_req     = 1'b0;
    imem_cmd     = 1'b0;
    imem_addr    = '0;
    port_req_ack = '0;
    port_rdata   = '0;
    port_resp    = '0;
    passed       = 0;
    total        = 0;

    do_reset(2);
    step(1'b0, 32'h0, 3'b000, 6'b0, 96'h0);

    // Single fetch to port 1.
    step(1'b1, 32'h00010004, 3'b010, 6'b0, 96'h0);
    chk("t1_preq", 32'(preq0), 32'b010);
    step(1'b0, 32'h0, 3'b000, {2'b00, 2'b01, 2'b00}, {32'h0, 32'hDEADBEEF, 32'h0});
    chk("t1_resp", 32'(resp0), 32'b01);
    chk("t1_rdata", rdata0, 32'hDEADBEEF);
    step(1'b0, 32'h0, 3'b000, 6'b0, 96'h0);

    // Back-to-back fetches to port 0; the third waits for the first response.
    step(1'b1, 32'h00000100, 3'b001, 6'b0, 96'h0);
    step(1'b1, 32'h00000104, 3'b001, 6'b0, 96'h0);
    chk("t2_ack2", 32'(ack0), 1);
    step(1'b1, 32'h00000108, 3'b001, 6'b0, 96'h0);
    chk("t2_full_ack", 32'(ack0), 0);
    chk("t2_full_preq", 32'(preq0), 0);
    step(1'b1, 32'h00000108, 3'b001, 6'b000001, {64'h0, 32'h111});
    chk("t2_ack3", 32'(ack0), 1);
    chk("t2_rd1", rdata0, 32'h111);
    step(1'b0, 32'h0, 3'b000, 6'b000001, {64'h0, 32'h222});
    chk("t2_rd2", rdata0, 32'h222);
    step(1'b0, 32'h0, 3'b000, 6'b000001, {64'h0, 32'h333});
    chk("t2_rd3", rdata0, 32'h333);
    step(1'b0, 32'h0, 3'b000, 6'b0, 96'h0);

    // Port switch 1 -> 2 issues only in the cycle port 1 retires.
    step(1'b1, 32'h00010000, 3'b010, 6'b0, 96'h0);
    step(1'b1, 32'h00020000, 3'b100, 6'b0, 96'h0);
    chk("t3_block_preq", 32'(preq0), 0);
    chk("t3_block_ack", 32'(ack0), 0);
    step(1'b1, 32'h00020000, 3'b100, 6'b000100, {32'h0, 32'h5A5A5A5A, 32'h0});
    chk("t3_switch_preq", 32'(preq0), 32'b100);
    chk("t3_switch_ack", 32'(ack0), 1);
    step(1'b0, 32'h0, 3'b000, 6'b010000, {32'hA5A5A5A5, 64'h0});
    step(1'b0, 32'h0, 3'b000, 6'b0, 96'h0);

    // Unmapped address terminated internally by the error-mapping instance.
    step(1'b1, 32'h80000000, 3'b000, 6'b0, 96'h0);
    chk("t4_ack", 32'(ack1), 1);
    chk("t4_preq", 32'(preq1), 0);
    step(1'b0, 32'h0, 3'b000, 6'b0, {96{1'b1}});
    chk("t4_resp", 32'(resp1), 32'b10);
    chk("t4_rdata", rdata1, 0);
    step(1'b0, 32'h0, 3'b000, 6'b0, 96'h0);

    // Error from port 2 retires one entry only.
    step(1'b1, 32'h00020010, 3'b100, 6'b0, 96'h0);
    step(1'b1, 32'h00020014, 3'b100, 6'b0, 96'h0);
    step(1'b0, 32'h0, 3'b000, 6'b100000, 96'h0);
    chk("t5_err", 32'(resp0), 32'b10);
    step(1'b0, 32'h0, 3'b000, 6'b010000, {32'hCAFEF00D, 64'h0});
    chk("t5_ok", 32'(resp0), 32'b01);
    chk("t5_rdata", rdata0, 32'hCAFEF00D);
    step(1'b0, 32'h0, 3'b000, 6'b0, 96'h0);

    // Reset with two fetches outstanding; late response must be ignored.
    step(1'b1, 32'h00000000, 3'b001, 6'b0, 96'h0);
    step(1'b1, 32'h00000004, 3'b001, 6'b0, 96'h0);
    do_reset(2);
    step(1'b0, 32'h0, 3'b000, 6'b000001, {64'h0, 32'h12345678});
    chk("t6_resp", 32'(resp0), 0);
    step(1'b0, 32'h0, 3'b000, 6'b000001, {64'h0, 32'h12345678});

    // Random traffic against the model, with one reset in the middle.
    for (int n = 0; n < 600; n++) begin
      if (n == 300) do_reset(1);
      step(1'($urandom_range(0, 99) < 70), rnd_addr(), 3'($urandom),
           {rnd_resp(), rnd_resp(), rnd_resp()}, {32'($urandom), 32'($urandom), 32'($urandom)});
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
